// File: rtl/fp_exception_unit_if.sv
// -----------------------------------------------------------------------------
// fp_exception_unit_if
// Handshake and status bundle for fp_exception_unit.
//   master : producer/consumer side (drives operands, OUT_READY, STICKY_CLR)
//   slave  : the exception unit itself
// Signals:
//   IN_VALID/IN_READY     operand pair handshake
//   FP_OPERATION          00 add, 01 sub, 10 mul, 11 div
//   OP_A, OP_B            operands {sign, exp, man}, W = 1+EXP_W+MAN_W bits
//   OUT_VALID/OUT_READY   result handshake
//   OP_IS_EXCEPTION       1 when FP_EXCE is nonzero
//   FP_EXCE               0 none, 1 qNaN, 2 invalid, 3 divide-by-zero
//   STICKY                {dbz, invalid, nan}
//   STICKY_CLR            clears STICKY and all counters
//   CNT_NAN/INV/DBZ       saturating event counters
// -----------------------------------------------------------------------------
interface fp_exception_unit_if #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int CNT_W = 8
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             IN_VALID;
   logic             IN_READY;
   logic [1:0]       FP_OPERATION;
   logic [W-1:0]     OP_A;
   logic [W-1:0]     OP_B;
   logic             OUT_VALID;
   logic             OUT_READY;
   logic             OP_IS_EXCEPTION;
   logic [2:0]       FP_EXCE;
   logic [2:0]       STICKY;
   logic             STICKY_CLR;
   logic [CNT_W-1:0] CNT_NAN;
   logic [CNT_W-1:0] CNT_INV;
   logic [CNT_W-1:0] CNT_DBZ;

   modport master (
      output IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
      input  IN_READY, OUT_VALID, OP_IS_EXCEPTION, FP_EXCE, STICKY,
             CNT_NAN, CNT_INV, CNT_DBZ
   );

   modport slave (
      input  IN_VALID, FP_OPERATION, OP_A, OP_B, OUT_READY, STICKY_CLR,
      output IN_READY, OUT_VALID, OP_IS_EXCEPTION, FP_EXCE, STICKY,
             CNT_NAN, CNT_INV, CNT_DBZ
   );
endinterface

// File: rtl/fp_exception_unit.sv
// -----------------------------------------------------------------------------
// fp_exception_unit
// Two-stage exception pre-check for the FPU datapath. Stage 1 classifies both
// operands (NaN / inf / zero), stage 2 decides the exception code for
// ADD/SUB/MUL/DIV. Sticky flags and saturating counters record every
// delivered exception.
// Ports:
//   CLK    rising-edge clock
//   RST_N  asynchronous active-low reset
//   bus    fp_exception_unit_if.slave (handshakes, operands, result, status)
// -----------------------------------------------------------------------------
module fp_exception_unit #(
   parameter int EXP_W = 4,
   parameter int MAN_W = 3,
   parameter int CNT_W = 8
) (
   input logic               CLK,
   input logic               RST_N,
   fp_exception_unit_if.slave bus
);
   localparam int W = 1 + EXP_W + MAN_W;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [2:0] EX_NONE = 3'd0;
   localparam logic [2:0] EX_NAN  = 3'd1;
   localparam logic [2:0] EX_INV  = 3'd2;
   localparam logic [2:0] EX_DBZ  = 3'd3;

   function automatic logic exp_ones(input logic [W-1:0] v);
      return &v[W-2:MAN_W];
   endfunction

   function automatic logic exp_zero(input logic [W-1:0] v);
      return ~|v[W-2:MAN_W];
   endfunction

   function automatic logic man_zero(input logic [W-1:0] v);
      return ~|v[MAN_W-1:0];
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   // NaN dominates; inf/zero-only cases follow; divide-by-zero needs a finite
   // nonzero dividend (inf/0 is not an exception here).
   function automatic logic [2:0] decide(
      input logic [1:0] op,
      input logic sa, input logic sb,
      input logic na, input logic nb,
      input logic ia, input logic ib,
      input logic za, input logic zb
   );
      logic [2:0] e;
      e = EX_NONE;
      if (na || nb)                                         e = EX_NAN;
      else if ((op == OP_ADD) && ia && ib && (sa != sb))    e = EX_INV;
      else if ((op == OP_SUB) && ia && ib && (sa == sb))    e = EX_INV;
      else if ((op == OP_MUL) && ((za && ib) || (ia && zb))) e = EX_INV;
      else if ((op == OP_DIV) && ((za && zb) || (ia && ib))) e = EX_INV;
      else if ((op == OP_DIV) && zb && !za && !ia)          e = EX_DBZ;
      return e;
   endfunction

   logic             vld_p1;
   logic [1:0]       op_p1;
   logic             sa_p1, sb_p1;
   logic             nan_a_p1, nan_b_p1;
   logic             inf_a_p1, inf_b_p1;
   logic             zero_a_p1, zero_b_p1;
   logic [2:0]       dec_p1;

   logic             vld_p2;
   logic [2:0]       exce_p2;
   logic             isx_p2;

   logic             s2_ready;
   logic             in_ready;
   logic             xfer;

   logic [2:0]       sticky;
   logic [CNT_W-1:0] cnt_nan, cnt_inv, cnt_dbz;

   always_comb begin
      s2_ready = !vld_p2 || bus.OUT_READY;
      in_ready = !vld_p1 || s2_ready;
      xfer     = vld_p2 && bus.OUT_READY;
   end

   // ---- stage 1: operand classification ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        vld_p1 <= 1'b0;
      else if (in_ready) vld_p1 <= bus.IN_VALID;
   end

   always_ff @(posedge CLK) begin
      if (bus.IN_VALID && in_ready) begin
         op_p1     <= bus.FP_OPERATION;
         sa_p1     <= bus.OP_A[W-1];
         sb_p1     <= bus.OP_B[W-1];
         nan_a_p1  <= exp_ones(bus.OP_A) && !man_zero(bus.OP_A);
         nan_b_p1  <= exp_ones(bus.OP_B) && !man_zero(bus.OP_B);
         inf_a_p1  <= exp_ones(bus.OP_A) &&  man_zero(bus.OP_A);
         inf_b_p1  <= exp_ones(bus.OP_B) &&  man_zero(bus.OP_B);
         zero_a_p1 <= exp_zero(bus.OP_A) &&  man_zero(bus.OP_A);
         zero_b_p1 <= exp_zero(bus.OP_B) &&  man_zero(bus.OP_B);
      end
   end

   assign dec_p1 = decide(op_p1, sa_p1, sb_p1, nan_a_p1, nan_b_p1,
                          inf_a_p1, inf_b_p1, zero_a_p1, zero_b_p1);

   // ---- stage 2: exception decision / output register ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         vld_p2  <= 1'b0;
         exce_p2 <= EX_NONE;
         isx_p2  <= 1'b0;
      end else if (s2_ready) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            exce_p2 <= dec_p1;
            isx_p2  <= (dec_p1 != EX_NONE);
         end
      end
   end

   // ---- status: sticky flags and counters, updated on output transfer ----
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sticky  <= 3'b000;
         cnt_nan <= '0;
         cnt_inv <= '0;
         cnt_dbz <= '0;
      end else if (bus.STICKY_CLR) begin
         // clear wins; a coinciding exception is intentionally not recorded
         sticky  <= 3'b000;
         cnt_nan <= '0;
         cnt_inv <= '0;
         cnt_dbz <= '0;
      end else if (xfer) begin
         case (exce_p2)
            EX_NAN: begin sticky[0] <= 1'b1; cnt_nan <= sat_inc(cnt_nan); end
            EX_INV: begin sticky[1] <= 1'b1; cnt_inv <= sat_inc(cnt_inv); end
            EX_DBZ: begin sticky[2] <= 1'b1; cnt_dbz <= sat_inc(cnt_dbz); end
            default: ;
         endcase
      end
   end

   assign bus.IN_READY        = in_ready;
   assign bus.OUT_VALID       = vld_p2;
   assign bus.FP_EXCE         = exce_p2;
   assign bus.OP_IS_EXCEPTION = isx_p2;
   assign bus.STICKY          = sticky;
   assign bus.CNT_NAN         = cnt_nan;
   assign bus.CNT_INV         = cnt_inv;
   assign bus.CNT_DBZ         = cnt_dbz;
endmodule

// File: tb/tb_fp_exception_unit.sv
`timescale 1ns/1ps
module tb_fp_exception_unit;
   logic CLK   = 1'b0;
   logic RST_N = 1'b0;
   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   fp_exception_unit_if #(.EXP_W(4), .MAN_W(3),  .CNT_W(8)) bus0 ();
   fp_exception_unit_if #(.EXP_W(4), .MAN_W(3),  .CNT_W(2)) bus1 ();
   fp_exception_unit_if #(.EXP_W(8), .MAN_W(23), .CNT_W(8)) bus2 ();

   fp_exception_unit #(.EXP_W(4), .MAN_W(3),  .CNT_W(8)) u0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
   fp_exception_unit #(.EXP_W(4), .MAN_W(3),  .CNT_W(2)) u1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));
   fp_exception_unit #(.EXP_W(8), .MAN_W(23), .CNT_W(8)) u2 (.CLK(CLK), .RST_N(RST_N), .bus(bus2));

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One isolated transaction on u0: returns OUT_VALID one cycle after
   // acceptance, then the result two cycles after; the result is consumed.
   task automatic op0(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      output logic v_early, output logic v_out,
                      output logic [2:0] exce, output logic isx);
      bus0.FP_OPERATION = op;
      bus0.OP_A         = a;
      bus0.OP_B         = b;
      bus0.IN_VALID     = 1'b1;
      bus0.OUT_READY    = 1'b1;
      tick();
      bus0.IN_VALID = 1'b0;
      v_early = bus0.OUT_VALID;
      tick();
      v_out = bus0.OUT_VALID;
      exce  = bus0.FP_EXCE;
      isx   = bus0.OP_IS_EXCEPTION;
      tick();
   endtask

   task automatic test_reset();
      tick();
      tick();
      n_checks++;
      if (bus0.OUT_VALID !== 1'b0 || bus0.FP_EXCE !== 3'd0 || bus0.OP_IS_EXCEPTION !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b exce=%0d isx=%b, expected 0 0 0",
                  bus0.OUT_VALID, bus0.FP_EXCE, bus0.OP_IS_EXCEPTION);
      end
      n_checks++;
      if (bus0.STICKY !== 3'b000 || bus0.CNT_NAN !== 8'd0 || bus0.CNT_INV !== 8'd0 || bus0.CNT_DBZ !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_status: sticky=%b cnt=%0d/%0d/%0d, expected 000 0/0/0",
                  bus0.STICKY, bus0.CNT_NAN, bus0.CNT_INV, bus0.CNT_DBZ);
      end
      RST_N = 1'b1;
      tick();
      n_checks++;
      if (bus0.IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_in_ready: IN_READY=%b expected 1", bus0.IN_READY);
      end
   endtask

   // Directed single-pair vectors on u0 with cumulative status expectations.
   task automatic test_vectors();
      logic [1:0] ops [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
      logic [7:0] va  [9] = '{8'h78, 8'h78, 8'hF8, 8'hF8, 8'h80, 8'h38, 8'h00, 8'h7C, 8'h7F};
      logic [7:0] vb  [9] = '{8'hF8, 8'h78, 8'hF8, 8'h78, 8'h78, 8'h00, 8'h80, 8'h00, 8'h00};
      logic [2:0] xe  [9] = '{3'd2, 3'd0, 3'd2, 3'd0, 3'd2, 3'd3, 3'd2, 3'd1, 3'd1};
      logic [2:0] xs  [9] = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b110, 3'b110, 3'b111, 3'b111};
      logic [7:0] xn  [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
      logic [7:0] xi  [9] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4, 8'd4, 8'd4};
      logic [7:0] xd  [9] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1};
      logic ve, vo, ix;
      logic [2:0] ex;
      for (int i = 0; i < 9; i++) begin
         op0(ops[i], va[i], vb[i], ve, vo, ex, ix);
         n_checks++;
         if (ve !== 1'b0) begin
            n_fail++;
            $display("FAIL vec%0d_early_valid: OUT_VALID=%b expected 0", i, ve);
         end
         n_checks++;
         if (vo !== 1'b1 || ex !== xe[i] || ix !== (xe[i] != 3'd0)) begin
            n_fail++;
            $display("FAIL vec%0d_result: valid=%b exce=%0d isx=%b, expected 1 %0d %b",
                     i, vo, ex, ix, xe[i], (xe[i] != 3'd0));
         end
         n_checks++;
         if (bus0.STICKY !== xs[i] || bus0.CNT_NAN !== xn[i] || bus0.CNT_INV !== xi[i] || bus0.CNT_DBZ !== xd[i]) begin
            n_fail++;
            $display("FAIL vec%0d_status: sticky=%b nan/inv/dbz=%0d/%0d/%0d, expected %b %0d/%0d/%0d",
                     i, bus0.STICKY, bus0.CNT_NAN, bus0.CNT_INV, bus0.CNT_DBZ, xs[i], xn[i], xi[i], xd[i]);
         end
      end
   endtask

   task automatic test_clear();
      bus0.STICKY_CLR = 1'b1;
      tick();
      bus0.STICKY_CLR = 1'b0;
      n_checks++;
      if (bus0.STICKY !== 3'b000 || bus0.CNT_NAN !== 8'd0 || bus0.CNT_INV !== 8'd0 || bus0.CNT_DBZ !== 8'd0) begin
         n_fail++;
         $display("FAIL clear_status: sticky=%b cnt=%0d/%0d/%0d, expected 000 0/0/0",
                  bus0.STICKY, bus0.CNT_NAN, bus0.CNT_INV, bus0.CNT_DBZ);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0] ops [4] = '{2'd0, 2'd3, 2'd0, 2'd2};
      logic [7:0] va  [4] = '{8'h78, 8'h38, 8'h38, 8'h7F};
      logic [7:0] vb  [4] = '{8'hF8, 8'h00, 8'h38, 8'h00};
      logic [2:0] xe  [4] = '{3'd2, 3'd3, 3'd0, 3'd1};
      int   sent = 0;
      int   recv = 0;
      logic saw_stall = 1'b0;
      logic hold_pend = 1'b0;
      logic [2:0] held = 3'd0;
      for (int cyc = 0; cyc < 40 && recv < 4; cyc++) begin
         bus0.OUT_READY = !(cyc >= 3 && cyc <= 5);
         bus0.IN_VALID  = (sent < 4);
         if (sent < 4) begin
            bus0.FP_OPERATION = ops[sent];
            bus0.OP_A         = va[sent];
            bus0.OP_B         = vb[sent];
         end
         @(negedge CLK);
         if (hold_pend) begin
            n_checks++;
            if (bus0.OUT_VALID !== 1'b1 || bus0.FP_EXCE !== held) begin
               n_fail++;
               $display("FAIL b2b_hold cyc%0d: valid=%b exce=%0d, expected 1 %0d",
                        cyc, bus0.OUT_VALID, bus0.FP_EXCE, held);
            end
         end
         hold_pend = bus0.OUT_VALID && !bus0.OUT_READY;
         held      = bus0.FP_EXCE;
         if (!bus0.IN_READY) saw_stall = 1'b1;
         if (bus0.OUT_VALID && bus0.OUT_READY) begin
            n_checks++;
            if (bus0.FP_EXCE !== xe[recv]) begin
               n_fail++;
               $display("FAIL b2b_result%0d: exce=%0d expected %0d", recv, bus0.FP_EXCE, xe[recv]);
            end
            recv++;
         end
         if (bus0.IN_VALID && bus0.IN_READY) sent++;
         tick();
      end
      bus0.IN_VALID  = 1'b0;
      bus0.OUT_READY = 1'b1;
      n_checks++;
      if (recv !== 4 || saw_stall !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_flow: delivered=%0d stall_seen=%b, expected 4 1", recv, saw_stall);
      end
      n_checks++;
      if (bus0.STICKY !== 3'b111 || bus0.CNT_NAN !== 8'd1 || bus0.CNT_INV !== 8'd1 || bus0.CNT_DBZ !== 8'd1) begin
         n_fail++;
         $display("FAIL b2b_status: sticky=%b cnt=%0d/%0d/%0d, expected 111 1/1/1",
                  bus0.STICKY, bus0.CNT_NAN, bus0.CNT_INV, bus0.CNT_DBZ);
      end
   endtask

   // u1 has CNT_W=2: streams of DIV 1.0/0 saturate CNT_DBZ at 3.
   task automatic test_saturation();
      bus1.FP_OPERATION = 2'd3;
      bus1.OP_A         = 8'h38;
      bus1.OP_B         = 8'h00;
      bus1.OUT_READY    = 1'b1;
      bus1.IN_VALID     = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         tick();
         if (k == 5) bus1.IN_VALID = 1'b0;
         if (k == 4) begin
            n_checks++;
            if (bus1.CNT_DBZ !== 2'd2) begin
               n_fail++;
               $display("FAIL sat_count2: CNT_DBZ=%0d expected 2", bus1.CNT_DBZ);
            end
         end
         if (k == 5) begin
            n_checks++;
            if (bus1.CNT_DBZ !== 2'd3) begin
               n_fail++;
               $display("FAIL sat_count3: CNT_DBZ=%0d expected 3", bus1.CNT_DBZ);
            end
         end
      end
      n_checks++;
      if (bus1.CNT_DBZ !== 2'd3 || bus1.STICKY !== 3'b100) begin
         n_fail++;
         $display("FAIL sat_hold: CNT_DBZ=%0d sticky=%b, expected 3 100", bus1.CNT_DBZ, bus1.STICKY);
      end
      bus1.IN_VALID = 1'b1;
      tick();
      bus1.IN_VALID = 1'b0;
      tick();
      n_checks++;
      if (bus1.OUT_VALID !== 1'b1 || bus1.FP_EXCE !== 3'd3) begin
         n_fail++;
         $display("FAIL sat_sixth_result: valid=%b exce=%0d, expected 1 3", bus1.OUT_VALID, bus1.FP_EXCE);
      end
      bus1.STICKY_CLR = 1'b1;
      tick();
      bus1.STICKY_CLR = 1'b0;
      n_checks++;
      if (bus1.STICKY !== 3'b000 || bus1.CNT_DBZ !== 2'd0 || bus1.OUT_VALID !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_clear_priority: sticky=%b CNT_DBZ=%0d valid=%b, expected 000 0 0",
                  bus1.STICKY, bus1.CNT_DBZ, bus1.OUT_VALID);
      end
   endtask

   task automatic test_param_sweep();
      logic [1:0]  ops [2] = '{2'd1, 2'd0};
      logic [31:0] va  [2] = '{32'h7F800000, 32'h7FC00000};
      logic [31:0] vb  [2] = '{32'h7F800000, 32'h3F800000};
      logic [2:0]  xe  [2] = '{3'd2, 3'd1};
      bus2.OUT_READY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus2.FP_OPERATION = ops[i];
         bus2.OP_A         = va[i];
         bus2.OP_B         = vb[i];
         bus2.IN_VALID     = 1'b1;
         tick();
         bus2.IN_VALID = 1'b0;
         tick();
         n_checks++;
         if (bus2.OUT_VALID !== 1'b1 || bus2.FP_EXCE !== xe[i] || bus2.OP_IS_EXCEPTION !== 1'b1) begin
            n_fail++;
            $display("FAIL sweep%0d: valid=%b exce=%0d isx=%b, expected 1 %0d 1",
                     i, bus2.OUT_VALID, bus2.FP_EXCE, bus2.OP_IS_EXCEPTION, xe[i]);
         end
         tick();
      end
   endtask

   task automatic test_reset_flush();
      bus0.FP_OPERATION = 2'd3;
      bus0.OP_A         = 8'h38;
      bus0.OP_B         = 8'h00;
      bus0.OUT_READY    = 1'b0;
      bus0.IN_VALID     = 1'b1;
      tick();
      tick();
      bus0.IN_VALID = 1'b0;
      n_checks++;
      if (bus0.OUT_VALID !== 1'b1 || bus0.IN_READY !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_inflight: valid=%b in_ready=%b, expected 1 0", bus0.OUT_VALID, bus0.IN_READY);
      end
      #2;
      RST_N = 1'b0;
      #1;
      n_checks++;
      if (bus0.OUT_VALID !== 1'b0 || bus0.FP_EXCE !== 3'd0 || bus0.CNT_DBZ !== 8'd0) begin
         n_fail++;
         $display("FAIL flush_async: valid=%b exce=%0d CNT_DBZ=%0d, expected 0 0 0",
                  bus0.OUT_VALID, bus0.FP_EXCE, bus0.CNT_DBZ);
      end
      tick();
      RST_N          = 1'b1;
      bus0.OUT_READY = 1'b1;
      tick();
      tick();
      tick();
      n_checks++;
      if (bus0.OUT_VALID !== 1'b0 || bus0.CNT_DBZ !== 8'd0 || bus0.STICKY !== 3'b000 || bus0.IN_READY !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_after_release: valid=%b CNT_DBZ=%0d sticky=%b in_ready=%b, expected 0 0 000 1",
                  bus0.OUT_VALID, bus0.CNT_DBZ, bus0.STICKY, bus0.IN_READY);
      end
   endtask

   initial begin
      bus0.IN_VALID = 1'b0; bus0.OUT_READY = 1'b1; bus0.STICKY_CLR = 1'b0;
      bus0.FP_OPERATION = 2'd0; bus0.OP_A = '0; bus0.OP_B = '0;
      bus1.IN_VALID = 1'b0; bus1.OUT_READY = 1'b1; bus1.STICKY_CLR = 1'b0;
      bus1.FP_OPERATION = 2'd0; bus1.OP_A = '0; bus1.OP_B = '0;
      bus2.IN_VALID = 1'b0; bus2.OUT_READY = 1'b1; bus2.STICKY_CLR = 1'b0;
      bus2.FP_OPERATION = 2'd0; bus2.OP_A = '0; bus2.OP_B = '0;

      test_reset();
      test_vectors();
      test_clear();
      test_back_to_back();
      test_saturation();
      test_param_sweep();
      test_reset_flush();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fp_exception_unit.md
Name: fp_exception_unit

Overview:
- Pipelined, parametrised exception pre-check for the FPU datapath.
- Classifies both operands for any 1/EXP_W/MAN_W format and decides the IEEE-style exception for ADD/SUB/MUL/DIV.
- Returns the decision two cycles after acceptance over a valid/ready handshake.
- Maintains sticky exception flags and saturating per-class event counters for the FPU status register.

Parameters:
- EXP_W, 4, exponent field width (≥2).
- MAN_W, 3, mantissa field width (≥1). Operand width W = 1+EXP_W+MAN_W.
- CNT_W, 8, width of each exception event counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  operand pair valid.
- IN_READY  out  1  unit can accept a pair.
- FP_OPERATION  in  2  00 add, 01 sub, 10 mul, 11 div.
- OP_A, OP_B  in  W  operands, {sign, exp, man}.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accepts.
- OP_IS_EXCEPTION  out  1  registered; 1 when FP_EXCE ≠ 0.
- FP_EXCE  out  3  0 none, 1 qNaN propagate, 2 invalid (inf arithmetic), 3 divide-by-zero.
- STICKY  out  3  {dbz, invalid, nan}, set on each delivered exception.
- STICKY_CLR  in  1  synchronous clear of STICKY and counters.
- CNT_NAN, CNT_INV, CNT_DBZ  out  CNT_W each  saturating event counts.

Behaviour:
- Reset (RST_N=0, async): both pipeline valid bits 0, OUT_VALID=0, OP_IS_EXCEPTION=0, FP_EXCE=0, STICKY=0, all counters 0. IN_READY comes out of reset as 1.
- Classification (stage 1, registered):
  - exp all-ones & man≠0 → NaN.
  - exp all-ones & man=0 → inf.
  - exp=0 & man=0 → zero (either sign).
  - Stage 1 registers sign, inf, nan and zero bits plus the op code.
- Decision (stage 2, registered), priority order:
  - NaN on either operand → 1.
  - ADD with both inf and signs differ → 2.
  - SUB with both inf and signs equal → 2. This covers +inf−+inf and −inf−−inf.
  - MUL with zero×inf in either order → 2.
  - DIV with 0/0 or inf/inf → 2.
  - DIV with B zero, A finite nonzero → 3.
  - Otherwise → 0.
- Latency: exactly 2 cycles from IN_VALID&IN_READY to OUT_VALID under no stall. Throughput is 1 pair/cycle.
- Handshake:
  - Each stage advances when its output slot is empty or being consumed.
  - IN_READY = !s1_valid | s2_ready, where s2_ready = !OUT_VALID | OUT_READY.
  - Outputs are held stable while OUT_VALID & !OUT_READY.
  - IN_READY may depend combinationally on OUT_READY; no other comb path from input to output.
- Sticky/counters:
  - Update only on output transfer (OUT_VALID & OUT_READY) of a nonzero code.
  - The matching STICKY bit is set and its counter increments.
  - Counters saturate at 2^CNT_W−1 and do not wrap.
  - STICKY_CLR has priority over a simultaneous update: the result is cleared, and that event is lost.
- Stall: no pair is dropped or duplicated. Data accepted while stalled stays in stage 1.
- Reset mid-operation flushes both stages; in-flight pairs are discarded and no status is updated.

Test Plan:
- Default params, ADD 0x78 + 0xF8 (+inf + −inf) → 2 cycles later OUT_VALID=1, FP_EXCE=2, STICKY=3'b010, CNT_INV=1. ADD 0x78+0x78 → FP_EXCE=0.
- SUB 0xF8 − 0xF8 → FP_EXCE=2. SUB 0xF8 − 0x78 → 0. MUL 0x80 × 0x78 → 2. DIV 0x38 / 0x00 → 3. DIV 0x00 / 0x80 → 2.
- NaN priority: DIV 0x7C / 0x00 → FP_EXCE=1, not 3. MUL 0x7F × 0x00 → 1.
- Back-to-back, 4 pairs with OUT_READY low for 3 cycles mid-stream:
  - IN_READY drops once both stages are full.
  - All 4 results are delivered in order, unchanged.
  - Counters are updated once each.
- Saturation and clear with CNT_W=2: 5 div-by-zero transfers → CNT_DBZ=3. STICKY_CLR asserted on the same cycle as a 6th transfer → STICKY=0, CNT_DBZ=0.
- Param sweep EXP_W=8, MAN_W=23: 0x7F800000 − 0x7F800000 → 2; 0x7FC00000 + 1.0 → 1.
- Assert RST_N low with 2 pairs in flight → OUT_VALID=0 immediately (async); no counter change after release.
